// File: rtl/fpu_mant_mult_pkg.sv
// -----------------------------------------------------------------------------
// fpu_mant_mult_pkg
// Shared definitions for the FPU mantissa multiplier slice:
//   FP_EXP_W / FP_FRAC_W / FP_SIG_W : IEEE-754 single field widths
//   fmul_state_e                    : multiplier FSM states
// -----------------------------------------------------------------------------
package fpu_mant_mult_pkg;

    localparam int unsigned FP_EXP_W  = 8;
    localparam int unsigned FP_FRAC_W = 23;
    localparam int unsigned FP_SIG_W  = 24;

    typedef enum logic [1:0] {
        FMUL_IDLE = 2'd0,
        FMUL_BUSY = 2'd1,
        FMUL_DONE = 2'd2
    } fmul_state_e;

endpackage

// File: rtl/fpu_mant_mult_sig_extract.sv
// -----------------------------------------------------------------------------
// fpu_sig_extract
// Combinational IEEE-754 single -> significand with hidden bit.
// Zero and denormal operands (exponent == 0) get a hidden bit of 0.
// Ports:
//   op_i  [31:0]        IEEE single operand
//   sig_o [FP_SIG_W-1:0] {hidden, fraction}
// -----------------------------------------------------------------------------
module fpu_sig_extract
    import fpu_mant_mult_pkg::*;
(
    input  logic [31:0]          op_i,
    output logic [FP_SIG_W-1:0]  sig_o
);

    logic [FP_EXP_W-1:0]  exp_w;
    logic [FP_FRAC_W-1:0] frac_w;

    always_comb begin
        exp_w  = op_i[FP_FRAC_W +: FP_EXP_W];
        frac_w = op_i[FP_FRAC_W-1:0];
        sig_o  = {(exp_w != '0), frac_w};
    end

endmodule

// File: rtl/fpu_mant_mult.sv
// -----------------------------------------------------------------------------
// fpu_mant_mult
// Iterative unsigned MANT_W x MANT_W significand multiplier, retiring
// RADIX_BITS multiplier bits per clock. Start/busy/valid handshake.
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   start        request, accepted only in IDLE or DONE
//   flush        abort; forces IDLE, wins over start
//   opa, opb     IEEE single operands (sampled on the accepting edge)
//   mult_result  2*MANT_W-bit product, updated on entry to DONE
//   busy         high while iterating
//   valid        one-cycle pulse when mult_result is new
// Optional build macro:
//   FPU_MULT_EARLY_OUT_EN : a zero latched significand skips straight to DONE
// -----------------------------------------------------------------------------
module fpu_mant_mult
    import fpu_mant_mult_pkg::*;
#(
    parameter int unsigned MANT_W     = 24,
    parameter int unsigned RADIX_BITS = 2
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  flush,
    input  logic [31:0]           opa,
    input  logic [31:0]           opb,
    output logic [2*MANT_W-1:0]   mult_result,
    output logic                  busy,
    output logic                  valid
);

    localparam int unsigned N     = MANT_W / RADIX_BITS;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW    = 2 * MANT_W;

    fmul_state_e          state_q;
    logic [PW-1:0]        mcand_q;     // multiplicand, pre-shifted to the current digit weight
    logic [MANT_W-1:0]    mplier_q;
    logic [PW-1:0]        acc_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [PW-1:0]        result_q;
    logic                 busy_q;
    logic                 valid_q;

    logic [FP_SIG_W-1:0]  sig_a;
    logic [FP_SIG_W-1:0]  sig_b;
    logic [PW-1:0]        pp;
    logic [PW-1:0]        acc_d;
    logic                 early_out;

    fpu_sig_extract u_sig_a (.op_i(opa), .sig_o(sig_a));
    fpu_sig_extract u_sig_b (.op_i(opb), .sig_o(sig_b));

    // Shifting mcand left each step replaces the explicit << RADIX_BITS*step.
    always_comb begin
        pp    = mcand_q * PW'(mplier_q[RADIX_BITS-1:0]);
        acc_d = acc_q + pp;
`ifdef FPU_MULT_EARLY_OUT_EN
        early_out = (sig_a == '0) || (sig_b == '0);
`else
        early_out = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= FMUL_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else if (flush) begin
            state_q <= FMUL_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                FMUL_IDLE, FMUL_DONE: begin
                    if (start) begin
                        mcand_q  <= PW'(sig_a);
                        mplier_q <= MANT_W'(sig_b);
                        acc_q    <= '0;
                        cnt_q    <= CNT_W'(N - 1);
                        if (early_out) begin
                            result_q <= '0;
                            state_q  <= FMUL_DONE;
                            busy_q   <= 1'b0;
                            valid_q  <= 1'b1;
                        end else begin
                            state_q  <= FMUL_BUSY;
                            busy_q   <= 1'b1;
                            valid_q  <= 1'b0;
                        end
                    end else begin
                        state_q <= FMUL_IDLE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                    end
                end
                FMUL_BUSY: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << RADIX_BITS;
                    mplier_q <= mplier_q >> RADIX_BITS;
                    if (cnt_q == '0) begin
                        result_q <= acc_d;
                        state_q  <= FMUL_DONE;
                        busy_q   <= 1'b0;
                        valid_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= FMUL_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign mult_result = result_q;
    assign busy        = busy_q;
    assign valid       = valid_q;

endmodule

// File: tb/tb_fpu_mant_mult.sv
// -----------------------------------------------------------------------------
// tb_fpu_mant_mult
// Self-checking bench for fpu_mant_mult: vector table, hand-written corner
// sequences (back-to-back, start while busy, flush, async reset) and random
// operands checked against a significand-product reference.
// -----------------------------------------------------------------------------
module tb_fpu_mant_mult;

    localparam int unsigned MANT_W = 24;
    localparam int          NITER  = 12;
`ifdef FPU_MULT_EARLY_OUT_EN
    localparam int          ZERO_BUSY = 0;
`else
    localparam int          ZERO_BUSY = NITER;
`endif

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic                 flush;
    logic [31:0]          opa;
    logic [31:0]          opb;
    logic [2*MANT_W-1:0]  mult_result;
    logic                 busy;
    logic                 valid;

    int pass_cnt  = 0;
    int total_cnt = 0;

    fpu_mant_mult #(.MANT_W(24), .RADIX_BITS(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .flush       (flush),
        .opa         (opa),
        .opb         (opb),
        .mult_result (mult_result),
        .busy        (busy),
        .valid       (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
        int          nbusy;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Counts busy cycles until busy falls; bounded so a stuck DUT cannot hang.
    task automatic wait_valid(output int n);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            tick();
        end
    endtask

    function automatic logic [63:0] ref_sig(input logic [31:0] f);
        logic [63:0] s;
        s = 64'(f & 32'h007F_FFFF);
        if (((f >> 23) & 32'hFF) != 0) s = s + 64'h80_0000;
        return s;
    endfunction

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        return ref_sig(a) * ref_sig(b);
    endfunction

    initial begin
        int n;
        int n1;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] rexp;
        int rbusy;

        vecs[0] = '{32'h3F80_0000, 32'h3F80_0000, 64'h4000_0000_0000, NITER};
        vecs[1] = '{32'h3FC0_0000, 32'h3FC0_0000, 64'h9000_0000_0000, NITER};
        vecs[2] = '{32'h3FFF_FFFF, 32'h3FFF_FFFF, 64'hFFFF_FE00_0001, NITER};
        vecs[3] = '{32'h0000_0000, 32'h4049_0FDB, 64'h0,              ZERO_BUSY};
        vecs[4] = '{32'h0000_0001, 32'h3F80_0000, 64'h80_0000,        NITER};
        vecs[5] = '{32'h7F7F_FFFF, 32'hFF7F_FFFF, 64'hFFFF_FE00_0001, NITER};

        rst = 1'b0; start = 1'b0; flush = 1'b0; opa = '0; opb = '0;
        tick();
        chk("reset_busy",   64'(busy), 64'h0);
        chk("reset_valid",  64'(valid), 64'h0);
        chk("reset_result", 64'(mult_result), 64'h0);
        rst = 1'b1;
        tick();

        // Table vectors
        for (int i = 0; i < 6; i++) begin
            opa = vecs[i].a; opb = vecs[i].b; start = 1'b1;
            tick();
            start = 1'b0;
            opa = $urandom; opb = $urandom;
            wait_valid(n);
            chk($sformatf("vec%0d_busy_cycles", i), 64'(n), 64'(vecs[i].nbusy));
            chk($sformatf("vec%0d_valid", i), 64'(valid), 64'h1);
            chk($sformatf("vec%0d_result", i), 64'(mult_result), vecs[i].res);
            tick();
            chk($sformatf("vec%0d_valid_drop", i), 64'(valid), 64'h0);
            chk($sformatf("vec%0d_result_hold", i), 64'(mult_result), vecs[i].res);
        end

        // Back-to-back: second start issued in the DONE cycle
        opa = 32'h3FC0_0000; opb = 32'h3FC0_0000; start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(n);
        chk("b2b_first_valid", 64'(valid), 64'h1);
        chk("b2b_first_result", 64'(mult_result), 64'h9000_0000_0000);
        opa = 32'h3FFF_FFFF; opb = 32'h3FFF_FFFF; start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_no_gap_busy", 64'(busy), 64'h1);
        wait_valid(n);
        chk("b2b_second_busy_cycles", 64'(n), 64'(NITER));
        chk("b2b_second_result", 64'(mult_result), 64'hFFFF_FE00_0001);
        tick();

        // Start while busy is ignored
        opa = 32'h3FC0_0000; opb = 32'h3FC0_0000; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        opa = 32'h3F80_0000; opb = 32'h3F80_0000; start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(n);
        chk("ignore_start_busy_cycles", 64'(n + 5), 64'(NITER));
        chk("ignore_start_result", 64'(mult_result), 64'h9000_0000_0000);
        tick();
        chk("ignore_start_no_restart", 64'(busy), 64'h0);

        // Flush mid-operation keeps the last completed result
        opa = 32'h3F80_0000; opb = 32'h3F80_0000; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy_drop", 64'(busy), 64'h0);
        chk("flush_valid", 64'(valid), 64'h0);
        chk("flush_result_kept", 64'(mult_result), 64'h9000_0000_0000);
        n1 = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (valid === 1'b1 || busy === 1'b1) n1++;
        end
        chk("flush_no_late_activity", 64'(n1), 64'h0);

        // Start together with flush: flush wins
        opa = 32'h3F80_0000; opb = 32'h3F80_0000; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("start_flush_busy", 64'(busy), 64'h0);
        tick();
        chk("start_flush_valid", 64'(valid), 64'h0);

        // Asynchronous reset in the middle of an operation
        opa = 32'h3FC0_0000; opb = 32'h3FC0_0000; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_busy", 64'(busy), 64'h0);
        chk("async_rst_valid", 64'(valid), 64'h0);
        chk("async_rst_result", 64'(mult_result), 64'h0);
        tick();
        #3;
        rst = 1'b1;
        tick();
        chk("post_rst_idle", 64'(busy), 64'h0);
        opa = 32'h3F80_0000; opb = 32'h3F80_0000; start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(n);
        chk("post_rst_busy_cycles", 64'(n), 64'(NITER));
        chk("post_rst_result", 64'(mult_result), 64'h4000_0000_0000);
        tick();

        // Random operands against the significand-product model
        for (int r = 0; r < 24; r++) begin
            ra = $urandom; rb = $urandom;
            if (r % 6 == 0) ra = ra & 32'h8000_0000;
            if (r % 7 == 3) rb = rb & 32'h807F_FFFF;
            rexp  = ref_prod(ra, rb);
            rbusy = (ref_sig(ra) == 0 || ref_sig(rb) == 0) ? ZERO_BUSY : NITER;
            opa = ra; opb = rb; start = 1'b1;
            tick();
            start = 1'b0;
            opa = $urandom; opb = $urandom;
            wait_valid(n);
            chk($sformatf("rand%0d_busy_cycles", r), 64'(n), 64'(rbusy));
            chk($sformatf("rand%0d_valid", r), 64'(valid), 64'h1);
            chk($sformatf("rand%0d_result a=%08h b=%08h", r, ra, rb), 64'(mult_result), rexp);
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
